// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared pipeline types: op classes, controller states, decode op mapping
package rv32_pkg;

  typedef enum logic [1:0] {
    OPC_ALU    = 2'd0,
    OPC_LOAD   = 2'd1,
    OPC_MULDIV = 2'd2,
    OPC_CTRL   = 2'd3
  } op_class_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    REDIRECT = 2'd2
  } ctrl_state_t;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL,
    ALU_LOAD, ALU_MUL, ALU_DIV, ALU_REM, ALU_BRANCH, ALU_JAL, ALU_JALR, ALU_LUI
  } alu_op_t;

  // Single place where decode ops are bucketed for hazard purposes.
  function automatic op_class_t op_class_of(alu_op_t alu_op);
    case (alu_op)
      ALU_LOAD:                      return OPC_LOAD;
      ALU_MUL, ALU_DIV, ALU_REM:     return OPC_MULDIV;
      ALU_BRANCH, ALU_JAL, ALU_JALR: return OPC_CTRL;
      default:                       return OPC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - OF-stage decode inputs and stage control outputs of the controller
interface pipeline_ctrl_if;
  import rv32_pkg::*;

  logic        of_valid;
  logic [4:0]  of_rs1_sel;
  logic [4:0]  of_rs2_sel;
  logic [4:0]  of_rd_sel;
  op_class_t   of_op_class;
  logic        ex_redirect;
  logic        stall_if;
  logic        stall_of;
  logic        flush_of;
  logic        bubble_ex;
  logic        issue;
  logic        md_start;
  logic        md_busy;
  ctrl_state_t state;

  modport master (
    output of_valid, of_rs1_sel, of_rs2_sel, of_rd_sel, of_op_class, ex_redirect,
    input  stall_if, stall_of, flush_of, bubble_ex, issue, md_start, md_busy, state
  );

  modport slave (
    input  of_valid, of_rs1_sel, of_rs2_sel, of_rd_sel, of_op_class, ex_redirect,
    output stall_if, stall_of, flush_of, bubble_ex, issue, md_start, md_busy, state
  );
endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use compare of OF sources against the instruction in EX
module hazard_detect (
  input  logic       of_valid,
  input  logic [4:0] of_rs1_sel,
  input  logic [4:0] of_rs2_sel,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd,
  output logic       load_use
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = of_valid & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                    ((of_rs1_sel == ex_rd) | (of_rs2_sel == ex_rd));
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - hazard/sequencing controller between OF and the OF->EX register
module pipeline_ctrl
  import rv32_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((MD_LAT > 1) ? MD_LAT - 2 : 0);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ex_valid_q, ex_valid_d;
  logic             ex_is_load_q, ex_is_load_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             load_use;

  logic stall_if_c, stall_of_c, flush_of_c, bubble_ex_c, issue_c, md_start_c, md_busy_c;

  hazard_detect u_hazard (
    .of_valid   (bus.of_valid),
    .of_rs1_sel (bus.of_rs1_sel),
    .of_rs2_sel (bus.of_rs2_sel),
    .ex_valid   (ex_valid_q),
    .ex_is_load (ex_is_load_q),
    .ex_rd      (ex_rd_q),
    .load_use   (load_use)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ex_valid_d   = ex_valid_q;
    ex_is_load_d = ex_is_load_q;
    ex_rd_d      = ex_rd_q;
    stall_if_c   = 1'b0;
    stall_of_c   = 1'b0;
    flush_of_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    issue_c      = 1'b0;
    md_start_c   = 1'b0;
    md_busy_c    = 1'b0;

    if (rst) begin
      bubble_ex_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.ex_redirect) begin
            flush_of_c  = 1'b1;
            bubble_ex_c = 1'b1;
            state_d     = REDIRECT;
          end else if (load_use) begin
            stall_if_c  = 1'b1;
            stall_of_c  = 1'b1;
            bubble_ex_c = 1'b1;
          end else if (bus.of_valid && bus.of_op_class == OPC_MULDIV) begin
            issue_c    = 1'b1;
            md_start_c = 1'b1;
            if (MD_LAT > 1) begin
              cnt_d   = CNT_INIT;
              state_d = MD_BUSY;
            end
          end else if (bus.of_valid) begin
            issue_c = 1'b1;
          end else begin
            bubble_ex_c = 1'b1;
          end
        end
        MD_BUSY: begin
          // EX keeps the MUL/DIV op; a redirect here is illegal and ignored.
          md_busy_c  = 1'b1;
          stall_if_c = 1'b1;
          stall_of_c = 1'b1;
          if (cnt_q == '0) state_d = RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        REDIRECT: begin
          flush_of_c  = 1'b1;
          bubble_ex_c = 1'b1;
          state_d     = RUN;
        end
        default: begin
          bubble_ex_c = 1'b1;
          state_d     = RUN;
        end
      endcase

      if (issue_c) begin
        ex_valid_d   = 1'b1;
        ex_is_load_d = (bus.of_op_class == OPC_LOAD);
        ex_rd_d      = bus.of_rd_sel;
      end else if (state_q != MD_BUSY) begin
        ex_valid_d   = 1'b0;
        ex_is_load_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      ex_valid_q   <= 1'b0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ex_valid_q   <= ex_valid_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  assign bus.stall_if  = stall_if_c;
  assign bus.stall_of  = stall_of_c;
  assign bus.flush_of  = flush_of_c;
  assign bus.bubble_ex = bubble_ex_c;
  assign bus.issue     = issue_c;
  assign bus.md_start  = md_start_c;
  assign bus.md_busy   = md_busy_c;
  assign bus.state     = rst ? RUN : state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed bench for pipeline_ctrl with MD_LAT=4 and MD_LAT=1 instances
module tb_pipeline_ctrl;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       of_valid;
  logic [4:0] of_rs1_sel, of_rs2_sel, of_rd_sel;
  op_class_t  of_op_class;
  logic       ex_redirect;

  pipeline_ctrl_if if4 ();
  pipeline_ctrl_if if1 ();

  assign if4.of_valid    = of_valid;
  assign if4.of_rs1_sel  = of_rs1_sel;
  assign if4.of_rs2_sel  = of_rs2_sel;
  assign if4.of_rd_sel   = of_rd_sel;
  assign if4.of_op_class = of_op_class;
  assign if4.ex_redirect = ex_redirect;
  assign if1.of_valid    = of_valid;
  assign if1.of_rs1_sel  = of_rs1_sel;
  assign if1.of_rs2_sel  = of_rs2_sel;
  assign if1.of_rd_sel   = of_rd_sel;
  assign if1.of_op_class = of_op_class;
  assign if1.ex_redirect = ex_redirect;

  pipeline_ctrl #(.MD_LAT(4), .CNT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  pipeline_ctrl #(.MD_LAT(1), .CNT_W(4)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Packed order: stall_if stall_of flush_of bubble_ex issue md_start md_busy state[1:0]
  function automatic logic [31:0] ctl(input logic si, so, fl, bu, is, ms, mb,
                                      input logic [1:0] st);
    return {23'd0, si, so, fl, bu, is, ms, mb, st};
  endfunction

  function automatic logic [31:0] obs4();
    return {23'd0, if4.stall_if, if4.stall_of, if4.flush_of, if4.bubble_ex,
            if4.issue, if4.md_start, if4.md_busy, if4.state};
  endfunction

  function automatic logic [31:0] obs1();
    return {23'd0, if1.stall_if, if1.stall_of, if1.flush_of, if1.bubble_ex,
            if1.issue, if1.md_start, if1.md_busy, if1.state};
  endfunction

  task automatic drive(input logic v, input op_class_t c, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic redir);
    of_valid    = v;
    of_op_class = c;
    of_rs1_sel  = rs1;
    of_rs2_sel  = rs2;
    of_rd_sel   = rd;
    ex_redirect = redir;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int starts, issues, first_start, second_start;

  initial begin
    rst = 1'b1;
    drive(1'b0, OPC_ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk);
    chk("reset_outputs", obs4(), ctl(0,0,0,1,0,0,0,2'd0));
    next_cycle();
    next_cycle();
    rst = 1'b0;

    // Load-use via rs1
    drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd5, 1'b0);
    @(negedge clk); chk("lw_issue", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd5, 5'd0, 5'd6, 1'b0);
    @(negedge clk); chk("lu_rs1_stall", obs4(), ctl(1,1,0,1,0,0,0,2'd0));
    next_cycle();
    @(negedge clk); chk("lu_rs1_release", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // Load-use via rs2
    drive(1'b1, OPC_LOAD, 5'd3, 5'd4, 5'd5, 1'b0);
    @(negedge clk); chk("lw2_issue", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd0, 5'd5, 5'd6, 1'b0);
    @(negedge clk); chk("lu_rs2_stall", obs4(), ctl(1,1,0,1,0,0,0,2'd0));
    next_cycle();
    @(negedge clk); chk("lu_rs2_release", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // Load to x0 never stalls, even when consumers read x0
    drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd0, 1'b0);
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd0, 5'd0, 5'd3, 1'b0);
    @(negedge clk); chk("lu_x0_no_stall", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // Independent consumer after a load
    drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd7, 1'b0);
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd8, 5'd9, 5'd10, 1'b0);
    @(negedge clk); chk("lu_indep", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // MUL/DIV occupancy: MD_LAT=4 busies 3 cycles, MD_LAT=1 none
    drive(1'b1, OPC_MULDIV, 5'd1, 5'd2, 5'd4, 1'b0);
    @(negedge clk);
    chk("md4_start", obs4(), ctl(0,0,0,0,1,1,0,2'd0));
    chk("md1_start", obs1(), ctl(0,0,0,0,1,1,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd1, 5'd0, 5'd2, 1'b0);
    @(negedge clk);
    chk("md4_busy1", obs4(), ctl(1,1,0,0,0,0,1,2'd1));
    chk("md1_no_busy", obs1(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();
    @(negedge clk); chk("md4_busy2", obs4(), ctl(1,1,0,0,0,0,1,2'd1));
    next_cycle();
    @(negedge clk); chk("md4_busy3", obs4(), ctl(1,1,0,0,0,0,1,2'd1));
    next_cycle();
    @(negedge clk); chk("md4_add_issue", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // Redirect: two flush cycles
    drive(1'b1, OPC_ALU, 5'd1, 5'd2, 5'd3, 1'b1);
    @(negedge clk); chk("redir_run", obs4(), ctl(0,0,1,1,0,0,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd1, 5'd2, 5'd3, 1'b0);
    @(negedge clk); chk("redir_state", obs4(), ctl(0,0,1,1,0,0,0,2'd2));
    next_cycle();
    @(negedge clk); chk("redir_back_run", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();

    // Redirect coincident with load-use
    drive(1'b1, OPC_LOAD, 5'd1, 5'd2, 5'd5, 1'b0);
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd5, 5'd0, 5'd6, 1'b1);
    @(negedge clk); chk("redir_beats_lu", obs4(), ctl(0,0,1,1,0,0,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd5, 5'd0, 5'd6, 1'b0);
    @(negedge clk); chk("redir_lu_state", obs4(), ctl(0,0,1,1,0,0,0,2'd2));
    next_cycle();
    drive(1'b0, OPC_ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk); chk("idle_bubble", obs4(), ctl(0,0,0,1,0,0,0,2'd0));
    next_cycle();

    // Back-to-back MULs
    starts = 0; issues = 0; first_start = -1; second_start = -1;
    drive(1'b1, OPC_MULDIV, 5'd1, 5'd2, 5'd3, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if4.md_start) begin
        starts++;
        if (first_start < 0) first_start = i;
        else if (second_start < 0) second_start = i;
      end
      if (if4.issue) issues++;
      next_cycle();
    end
    chk("b2b_issue_count", issues, 32'd2);
    chk("b2b_start_count", starts, 32'd2);
    chk("b2b_spacing", second_start - first_start, 32'd4);
    drive(1'b0, OPC_ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    next_cycle();

    // Reset in the second MD_BUSY cycle
    drive(1'b1, OPC_MULDIV, 5'd1, 5'd2, 5'd3, 1'b0);
    @(negedge clk); chk("rst_md_issue", obs4(), ctl(0,0,0,0,1,1,0,2'd0));
    next_cycle();
    drive(1'b1, OPC_ALU, 5'd1, 5'd2, 5'd3, 1'b0);
    @(negedge clk); chk("rst_md_busy1", obs4(), ctl(1,1,0,0,0,0,1,2'd1));
    next_cycle();
    rst = 1'b1;
    @(negedge clk); chk("rst_drops_busy", obs4(), ctl(0,0,0,1,0,0,0,2'd0));
    next_cycle();
    @(negedge clk); chk("rst_held", obs4(), ctl(0,0,0,1,0,0,0,2'd0));
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_issue4", obs4(), ctl(0,0,0,0,1,0,0,2'd0));
    chk("post_rst_issue1", obs1(), ctl(0,0,0,0,1,0,0,2'd0));
    next_cycle();
    drive(1'b0, OPC_ALU, 5'd0, 5'd0, 5'd0, 1'b0);
    @(negedge clk); chk("post_rst_run", obs4(), ctl(0,0,0,1,0,0,0,2'd0));
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
